imm_encoder: RTL
================

# imm_encoder

Streaming immediate encoder: takes a base instruction word with its immediate field zeroed, plus a 32-bit immediate and an immediate format, and scatters the immediate into the RISC-V I/S/B/U/J bit positions. It checks that the immediate is representable and aligned, and emits the finished word with a sequential instruction-memory address. It sits on the program-load/test path ahead of instruction memory. It is the exact inverse of the core's immediate decode, so decode(encode(imm)) == imm for every legal imm.

## Interface
- DATA_WIDTH, 32, instruction/immediate width (only 32 supported)
- ADDR_WIDTH, 12, byte-address width of out_addr
- BASE_ADDR, 0, address of first emitted word and value after flush

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  sync clear of pipeline and address
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid && in_ready
- imm_sel  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5..7 illegal
- base_instr  in  DATA_WIDTH  opcode/funct/reg fields; immediate bit positions are overwritten
- imm  in  DATA_WIDTH  signed byte immediate; for U, full value with imm[11:0]==0
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer ready
- out_instr  out  DATA_WIDTH  encoded instruction
- out_addr  out  ADDR_WIDTH  byte address of out_instr
- err_range  out  1  one-cycle pulse: immediate out of range or illegal imm_sel
- err_align  out  1  one-cycle pulse: required low bits non-zero
- err_count  out  8  saturating count of rejected inputs

## Operation
- Placement:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - All other bits pass from base_instr.
- Range checks (signed):
  - I/S: -2048..2047
  - B: -4096..4094, imm[0]==0
  - J: -2^20..2^20-2, imm[0]==0
  - U: imm[11:0]==0
- Illegal imm_sel → err_range.
- Range and alignment failures may both pulse for the same input.
- Rejected inputs are dropped. No output word, and out_addr does not advance.
- Each rejected input increments err_count, which saturates at 255.
- out_addr increments by 4 on each out handshake and wraps modulo 2^ADDR_WIDTH.

## Timing
- Two-stage pipeline:
  - S1 holds the check and pack result.
  - S2 is the output register.
  - Latency is 2 cycles from acceptance to out_valid. Throughput is 1 word/cycle.
- Ready chaining:
  - s2_ready = !out_valid || out_ready
  - in_ready = !s1_valid || s1_err || s2_ready
  - in_ready is combinational from out_ready.
- An erroneous S1 entry retires the next cycle regardless of S2 state.
- err_* pulses in the cycle after acceptance (S1 occupancy).
- out_instr and out_addr are held stable while out_valid && !out_ready.
- flush:
  - Next edge: S1/S2 are invalid and out_addr=BASE_ADDR.
  - err_count is not cleared.
  - Same-cycle input is not accepted (in_ready forced 0).
  - Flush overrides a simultaneous out handshake.
- Reset values:
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR
  - err_range=0, err_align=0, err_count=0
  - Internal valids are 0, so in_ready=1 after reset.

## Configuration
- IMM_ENCODER_RANGE_CHECK_EN defined: checks, error pulses and err_count behave as above.
- Undefined:
  - No checks; every input is encoded by truncation and emitted.
  - Illegal imm_sel emits base_instr unchanged.
  - err_range, err_align and err_count are tied to 0.

## Structure
- Shared package holds:
  - The imm_sel enum (IMM_I..IMM_J), shared with the core decoder.
  - Range constants: I/S, B and J min/max.
- Sub-module imm_pack: purely combinational placement (imm, imm_sel, base_instr → word). Reused by the bench as the golden model.

## Test plan
- I-type: base 0x00000093, imm=-1, sel=0 → out_instr 0xFFF00093, out_addr 0x000.
- S and B back-to-back:
  - Inputs: sw base 0x00002023 with imm=8; then beq base 0x00000063 with imm=-4.
  - Outputs: 0x00002423 @0x000, then 0xFE000EE3 @0x004 on consecutive cycles.
- J-type: base 0x000000EF, imm=2048 → 0x001000EF.
- Errors:
  - I-type imm=2048 → err_range pulse, no out_valid, err_count=1.
  - B-type imm=3 → err_align pulse.
  - Next legal word still lands at the unadvanced address.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles, 4 inputs offered.
  - Response: 2 accepted, then in_ready=0; drain yields words in order @0x0, 0x4, 0x8, 0xC.
- Reset/flush mid-stream:
  - flush with S1 and S2 full → out_valid=0 next cycle, next word @BASE_ADDR, err_count retained.
  - rst_n low mid-stream → all outputs return to reset values asynchronously.
- Round-trip: 10k random legal (imm, sel) → core decode of out_instr equals imm.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the encoder and the core decoder:
// format select enum, signed range limits and the representability check.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  localparam int signed IS_MIN = -2048;
  localparam int signed IS_MAX = 2047;
  localparam int signed B_MIN  = -4096;
  localparam int signed B_MAX  = 4094;
  localparam int signed J_MIN  = -(1 << 20);
  localparam int signed J_MAX  = (1 << 20) - 2;

  typedef struct packed {
    logic range_err;
    logic align_err;
  } imm_chk_t;

  // Range and alignment are reported independently so both may flag one input.
  function automatic imm_chk_t imm_check(input logic [2:0] sel, input logic [31:0] imm);
    imm_chk_t   r;
    int signed  v;
    r = '0;
    v = $signed(imm);
    case (sel)
      IMM_I, IMM_S: r.range_err = (v < IS_MIN) || (v > IS_MAX);
      IMM_B: begin
        r.range_err = (v < B_MIN) || (v > B_MAX);
        r.align_err = imm[0];
      end
      IMM_J: begin
        r.range_err = (v < J_MIN) || (v > J_MAX);
        r.align_err = imm[0];
      end
      IMM_U:   r.align_err = |imm[11:0];
      default: r.range_err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational scatter of an immediate into the RISC-V I/S/B/U/J bit slots;
// bits outside the selected slots (and all bits for an illegal select) pass from base.
module imm_pack
  import imm_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            imm_sel,
  input  logic [DATA_WIDTH-1:0] base_instr,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [DATA_WIDTH-1:0] instr
);

  always_comb begin
    instr = base_instr;
    case (imm_sel)
      IMM_I: instr[31:20] = imm[11:0];
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
      end
      IMM_U: instr[31:12] = imm[31:12];
      IMM_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage streaming immediate encoder with sequential output addressing.
// Define IMM_ENCODER_RANGE_CHECK_EN to enable range/alignment rejection and error reporting.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            imm_sel,
  input  logic [DATA_WIDTH-1:0] base_instr,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_range,
  output logic                  err_align,
  output logic [7:0]            err_count
);

  logic [DATA_WIDTH-1:0] packed_instr;
  logic                  chk_range;
  logic                  chk_align;
  logic                  chk_err;

  logic                  s2_ready;
  logic                  s1_adv;
  logic                  in_ready_c;
  logic                  accept;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_instr_q, s1_instr_d;
  logic                  err_range_q, err_range_d;
  logic                  err_align_q, err_align_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

  imm_pack #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pack (
    .imm_sel    (imm_sel),
    .base_instr (base_instr),
    .imm        (imm),
    .instr      (packed_instr)
  );

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  imm_chk_t chk;
  always_comb begin
    chk       = imm_check(imm_sel, imm);
    chk_range = chk.range_err;
    chk_align = chk.align_err;
    chk_err   = chk.range_err | chk.align_err;
  end
`else
  always_comb begin
    chk_range = 1'b0;
    chk_align = 1'b0;
    chk_err   = 1'b0;
  end
`endif

  // An erroneous S1 entry never waits on S2, so it never blocks the input.
  always_comb begin
    s2_ready   = !out_valid_q || out_ready;
    s1_adv     = s1_valid_q && !s1_err_q && s2_ready;
    in_ready_c = !flush && (!s1_valid_q || s1_err_q || s2_ready);
    accept     = in_valid && in_ready_c;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_err_d    = s1_err_q;
    s1_instr_d  = s1_instr_q;
    err_range_d = 1'b0;
    err_align_d = 1'b0;
    err_count_d = err_count_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      s1_err_d    = 1'b0;
      out_valid_d = 1'b0;
      out_addr_d  = BASE_ADDR;
    end else begin
      // out_addr labels the word in S2, so it advances only once that word leaves.
      if (out_valid_q && out_ready) begin
        out_addr_d = out_addr_q + ADDR_WIDTH'(3'd4);
      end
      if (s2_ready) begin
        out_valid_d = s1_adv;
        if (s1_adv) begin
          out_instr_d = s1_instr_q;
        end
      end

      if (accept) begin
        s1_valid_d = 1'b1;
        s1_err_d   = chk_err;
        s1_instr_d = packed_instr;
      end else if (s1_adv || s1_err_q) begin
        s1_valid_d = 1'b0;
        s1_err_d   = 1'b0;
      end

      err_range_d = accept && chk_range;
      err_align_d = accept && chk_align;
      if (accept && chk_err && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_instr_q  <= '0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
      err_count_q <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_instr_q  <= s1_instr_d;
      err_range_q <= err_range_d;
      err_align_q <= err_align_d;
      err_count_q <= err_count_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
    end
  end

  always_comb begin
    in_ready  = in_ready_c;
    out_valid = out_valid_q;
    out_instr = out_instr_q;
    out_addr  = out_addr_q;
    err_range = err_range_q;
    err_align = err_align_q;
    err_count = err_count_q;
  end

endmodule
